fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  - IF stage of the LEGv8 pipeline: owns the PC, drives the word address to the instruction memory, captures the returned word into the IF/ID register.
//  - Downstream: decode consumes ifid_*. Upstream/side: EX/MEM branch resolution supplies pcsrc/branch_target.
//  - Handles stall (hold), branch redirect (flush + reload PC) and sequential PC+4 advance.
// PARAMETERS
//  N        64            PC / branch_target / ifid_pc width (bits)
//  RESET_PC 64'h0         PC value loaded on reset
//  NOP_WORD 32'h8b1f03ff  bubble instruction (ADD XZR,XZR,XZR) inserted on flush
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  reset          in   1   synchronous active-low reset (0 = reset)
//  stall          in   1   hazard unit: hold PC and IF/ID this cycle
//  pcsrc          in   1   taken branch resolved: redirect fetch
//  branch_target  in   N   redirect PC (byte address)
//  imem_addr      out  8   instruction-memory word address = pc_q[9:2]
//  imem_q         in   32  instruction word returned for imem_addr (combinational)
//  ifid_pc        out  N   PC of instruction held in IF/ID
//  ifid_instr     out  32  instruction held in IF/ID
//  ifid_valid     out  1   1 = IF/ID holds a real fetched instruction
//  pc_out         out  N   current PC (pc_q), for debug/trace
//  halted         out  1   only when FETCH_HALT_EN defined (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset==0 at edge): pc_q<=RESET_PC; ifid_pc<=0; ifid_instr<=NOP_WORD; ifid_valid<=0; halted<=0. Reset mid-operation discards everything in flight; first fetch after release is at RESET_PC.
//  - imem_addr combinational from pc_q[9:2]; fetch latency 1 cycle: word at pc_q appears on ifid_instr after the next edge.
//  - Per-edge priority: reset > pcsrc > stall > halt condition (if enabled) > normal.
//  - pcsrc=1: pc_q<={branch_target[N-1:2],2'b00}; IF/ID flushed (ifid_valid<=0, ifid_instr<=NOP_WORD, ifid_pc<=0). Wins over simultaneous stall; clears halted.
//  - stall=1 (pcsrc=0): pc_q and all ifid_* hold their values.
//  - normal: ifid_instr<=imem_q; ifid_pc<=pc_q; ifid_valid<=1; pc_q<=pc_q+4.
//  - Arithmetic: PC+4 is modulo 2^N (wraps silently). imem_addr covers 256 words; PC bits above [9] ignored for addressing (window aliases every 1 KiB).
//  - Misaligned branch_target: bits [1:0] forced to 0, no error.
//  - Words beyond the populated memory read as 0; fetch treats them as ordinary data unless FETCH_HALT_EN.
//  - Outputs are registered except imem_addr (from pc_q) and pc_out (=pc_q).
// CONFIGURATION
//  - Macro FETCH_HALT_EN.
//  - Defined: port halted exists. On a normal-priority edge with imem_q==32'h0: pc_q holds, IF/ID loads bubble (valid 0, NOP_WORD), halted<=1 (sticky). While halted, fetch stays frozen regardless of stall; only pcsrc=1 or reset resumes (both clear halted).
//  - Not defined: no halted port; all-zero word is latched as a valid instruction and PC advances normally.
// TESTING
//  1. reset=0 for 2 edges, imem_q=32'hf8000001 -> pc_out=0, imem_addr=0, ifid_valid=0, ifid_instr=32'h8b1f03ff; release -> next edge ifid_instr=32'hf8000001, ifid_pc=0, ifid_valid=1, imem_addr=1.
//  2. 3 free-running edges after reset -> imem_addr 1,2,3; ifid_pc 0,4,8; pc_out 0xC.
//  3. stall=1 for 2 edges at pc_out=0x10 -> pc_out stays 0x10, ifid_* unchanged; stall=0 -> ifid_pc=0x10, pc_out=0x14.
//  4. pcsrc=1, branch_target=0x43, stall=1 same edge -> pc_out=0x40, imem_addr=0x10, ifid_valid=0, ifid_instr=32'h8b1f03ff; next edge ifid_pc=0x40, ifid_valid=1.
//  5. FETCH_HALT_EN, pc_out=0x2AC (imem_addr=171), imem_q=0 -> halted=1, pc_out stays 0x2AC, ifid_valid=0 for 3 edges even with stall toggling; pcsrc=1, target=0 -> halted=0, pc_out=0.
//  6. Without FETCH_HALT_EN, same stimulus as 5 -> ifid_instr=0, ifid_valid=1, pc_out=0x2B0; reset=0 mid-run at pc 0x80 -> pc_out=0, ifid_valid=0 next edge.

Source files
------------

// File: rtl/fetch_stage_if.sv
// IF-stage bus: instruction-memory read port plus the IF/ID register contents handed to decode.
// master = fetch stage, slave = memory/decode side.
interface fetch_stage_if #(
  parameter int N = 64
);
  logic [7:0]   imem_addr;
  logic [31:0]  imem_q;
  logic [N-1:0] ifid_pc;
  logic [31:0]  ifid_instr;
  logic         ifid_valid;

  modport master (
    output imem_addr,
    input  imem_q,
    output ifid_pc,
    output ifid_instr,
    output ifid_valid
  );

  modport slave (
    input  imem_addr,
    output imem_q,
    input  ifid_pc,
    input  ifid_instr,
    input  ifid_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: LEGv8 IF stage -- PC register, instruction-memory addressing and the IF/ID register.
// Optional macro FETCH_HALT_EN: an all-zero fetched word freezes fetch and raises o_halted.
module fetch_stage #(
  parameter int           N        = 64,
  parameter logic [N-1:0] RESET_PC = {N{1'b0}},
  parameter logic [31:0]  NOP_WORD = 32'h8b1f03ff
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_stall,
  input  logic          i_pcsrc,
  input  logic [N-1:0]  i_branch_target,
  fetch_stage_if.master bus,
  output logic [N-1:0]  o_pc_out
`ifdef FETCH_HALT_EN
  ,
  output logic          o_halted
`endif
);

  localparam logic [N-1:0] PC_STEP    = {{(N-3){1'b0}}, 3'b100};
  localparam logic [N-1:0] ALIGN_MASK = {{(N-2){1'b1}}, 2'b00};

  logic [N-1:0] r_pc;
  logic [N-1:0] r_ifid_pc;
  logic [31:0]  r_ifid_instr;
  logic         r_ifid_valid;

  logic [N-1:0] w_pc_nxt;
  logic [N-1:0] w_ifid_pc_nxt;
  logic [31:0]  w_ifid_instr_nxt;
  logic         w_ifid_valid_nxt;

`ifdef FETCH_HALT_EN
  logic r_halted;
  logic w_halted_nxt;
`endif

  // Next-state selection: redirect beats stall, stall beats halt, otherwise sequential fetch.
  always_comb begin
    w_pc_nxt         = r_pc;
    w_ifid_pc_nxt    = r_ifid_pc;
    w_ifid_instr_nxt = r_ifid_instr;
    w_ifid_valid_nxt = r_ifid_valid;
`ifdef FETCH_HALT_EN
    w_halted_nxt     = r_halted;
`endif
    if (i_pcsrc) begin
      w_pc_nxt         = i_branch_target & ALIGN_MASK;
      w_ifid_pc_nxt    = {N{1'b0}};
      w_ifid_instr_nxt = NOP_WORD;
      w_ifid_valid_nxt = 1'b0;
`ifdef FETCH_HALT_EN
      w_halted_nxt     = 1'b0;
`endif
    end else if (i_stall) begin
      w_pc_nxt         = r_pc;
      w_ifid_pc_nxt    = r_ifid_pc;
      w_ifid_instr_nxt = r_ifid_instr;
      w_ifid_valid_nxt = r_ifid_valid;
    end else begin
`ifdef FETCH_HALT_EN
      if (r_halted) begin
        w_pc_nxt         = r_pc;
        w_ifid_pc_nxt    = r_ifid_pc;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_valid_nxt = r_ifid_valid;
      end else if (bus.imem_q == 32'h0000_0000) begin
        // Empty memory word: park the PC on it and feed decode a bubble.
        w_pc_nxt         = r_pc;
        w_ifid_pc_nxt    = {N{1'b0}};
        w_ifid_instr_nxt = NOP_WORD;
        w_ifid_valid_nxt = 1'b0;
        w_halted_nxt     = 1'b1;
      end else begin
        w_pc_nxt         = r_pc + PC_STEP;
        w_ifid_pc_nxt    = r_pc;
        w_ifid_instr_nxt = bus.imem_q;
        w_ifid_valid_nxt = 1'b1;
      end
`else
      w_pc_nxt         = r_pc + PC_STEP;
      w_ifid_pc_nxt    = r_pc;
      w_ifid_instr_nxt = bus.imem_q;
      w_ifid_valid_nxt = 1'b1;
`endif
    end
  end

  // PC and IF/ID registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_pc         <= RESET_PC;
      r_ifid_pc    <= {N{1'b0}};
      r_ifid_instr <= NOP_WORD;
      r_ifid_valid <= 1'b0;
`ifdef FETCH_HALT_EN
      r_halted     <= 1'b0;
`endif
    end else begin
      r_pc         <= w_pc_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
`ifdef FETCH_HALT_EN
      r_halted     <= w_halted_nxt;
`endif
    end
  end

  assign bus.imem_addr  = r_pc[9:2];
  assign bus.ifid_pc    = r_ifid_pc;
  assign bus.ifid_instr = r_ifid_instr;
  assign bus.ifid_valid = r_ifid_valid;
  assign o_pc_out       = r_pc;
`ifdef FETCH_HALT_EN
  assign o_halted       = r_halted;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: table of per-edge vectors, a scoreboarded random-stall run,
// and a hand-written mid-run reset sequence. Works with or without FETCH_HALT_EN.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h8b1f03ff;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        stall  = 1'b0;
  logic        pcsrc  = 1'b0;
  logic [63:0] target = 64'h0;
  logic [63:0] pc_out;
  logic        halted;
  logic [31:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage_if #(.N(64)) bus ();

  assign bus.imem_q = mem[bus.imem_addr];

  fetch_stage #(.N(64), .RESET_PC(64'h0), .NOP_WORD(NOP)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_stall        (stall),
    .i_pcsrc        (pcsrc),
    .i_branch_target(target),
    .bus            (bus),
    .o_pc_out       (pc_out)
`ifdef FETCH_HALT_EN
    ,
    .o_halted       (halted)
`endif
  );

`ifndef FETCH_HALT_EN
  assign halted = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic        p;
    logic [63:0] t;
    logic [63:0] e_pc;
    logic        e_valid;
    logic [63:0] e_ifid_pc;
    logic [31:0] e_instr;
    logic        e_halted;
    bit          pc_dc;
  } vec_t;

  vec_t vecs[$];
  logic [95:0] sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic p, input logic [63:0] t, input logic r);
    @(negedge clk);
    stall  = s;
    pcsrc  = p;
    target = t;
    reset  = r;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic s, input logic p, input logic [63:0] t,
                              input logic [63:0] e_pc, input logic e_valid,
                              input logic [63:0] e_ifid_pc, input logic [31:0] e_instr,
                              input logic e_halted, input bit pc_dc);
    vec_t v;
    v.s = s; v.p = p; v.t = t;
    v.e_pc = e_pc; v.e_valid = e_valid; v.e_ifid_pc = e_ifid_pc;
    v.e_instr = e_instr; v.e_halted = e_halted; v.pc_dc = pc_dc;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] m_pc;
    logic [95:0] item;
    logic        rs;

    for (int i = 0; i < 256; i++) mem[i] = 32'hF800_0000 + 32'(i) + 32'd1;
    mem[171] = 32'h0000_0000;

    // Sequential fetch, stall, redirect with stall, halt/zero word, misaligned wrap-around redirect.
    vecs.push_back(mk(1'b0, 1'b0, 64'h0, 64'h4,  1'b1, 64'h0,  32'hF800_0001, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 64'h0, 64'h8,  1'b1, 64'h4,  32'hF800_0002, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 64'h0, 64'hC,  1'b1, 64'h8,  32'hF800_0003, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 64'h0, 64'h10, 1'b1, 64'hC,  32'hF800_0004, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 64'h0, 64'h10, 1'b1, 64'hC,  32'hF800_0004, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 64'h0, 64'h10, 1'b1, 64'hC,  32'hF800_0004, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 64'h0, 64'h14, 1'b1, 64'h10, 32'hF800_0005, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 64'h43, 64'h40, 1'b0, 64'h0, NOP,           1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 64'h0, 64'h44, 1'b1, 64'h40, 32'hF800_0011, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 64'h2AC, 64'h2AC, 1'b0, 64'h0, NOP,         1'b0, 1'b0));
    if (HALT_EN) begin
      vecs.push_back(mk(1'b0, 1'b0, 64'h0, 64'h2AC, 1'b0, 64'h0, NOP, 1'b1, 1'b1));
      vecs.push_back(mk(1'b1, 1'b0, 64'h0, 64'h2AC, 1'b0, 64'h0, NOP, 1'b1, 1'b1));
      vecs.push_back(mk(1'b0, 1'b0, 64'h0, 64'h2AC, 1'b0, 64'h0, NOP, 1'b1, 1'b1));
      vecs.push_back(mk(1'b1, 1'b0, 64'h0, 64'h2AC, 1'b0, 64'h0, NOP, 1'b1, 1'b1));
    end else begin
      vecs.push_back(mk(1'b0, 1'b0, 64'h0, 64'h2B0, 1'b1, 64'h2AC, 32'h0000_0000, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 64'h0, 64'h2B0, 1'b1, 64'h2AC, 32'h0000_0000, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 64'h0, 64'h2B4, 1'b1, 64'h2B0, 32'hF800_00AD, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 64'h0, 64'h2B4, 1'b1, 64'h2B0, 32'hF800_00AD, 1'b0, 1'b0));
    end
    vecs.push_back(mk(1'b1, 1'b1, 64'h0, 64'h0, 1'b0, 64'h0, NOP,           1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 64'h0, 64'h4, 1'b1, 64'h0, 32'hF800_0001, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0,
                      64'h0, NOP, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC,
                      32'hF800_0100, 1'b0, 1'b0));

    // Reset held for two edges.
    step(1'b0, 1'b0, 64'h0, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b0);
    chk("rst_pc_out",     pc_out,             64'h0);
    chk("rst_imem_addr",  64'(bus.imem_addr), 64'h0);
    chk("rst_ifid_valid", 64'(bus.ifid_valid), 64'h0);
    chk("rst_ifid_instr", 64'(bus.ifid_instr), 64'(NOP));
    chk("rst_ifid_pc",    bus.ifid_pc,        64'h0);
`ifdef FETCH_HALT_EN
    chk("rst_halted",     64'(halted),        64'h0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].s, vecs[i].p, vecs[i].t, 1'b1);
      chk($sformatf("v%0d_pc_out", i),     pc_out,              vecs[i].e_pc);
      chk($sformatf("v%0d_imem_addr", i),  64'(bus.imem_addr),  64'(vecs[i].e_pc[9:2]));
      chk($sformatf("v%0d_ifid_valid", i), 64'(bus.ifid_valid), 64'(vecs[i].e_valid));
      chk($sformatf("v%0d_ifid_instr", i), 64'(bus.ifid_instr), 64'(vecs[i].e_instr));
      if (!vecs[i].pc_dc) chk($sformatf("v%0d_ifid_pc", i), bus.ifid_pc, vecs[i].e_ifid_pc);
`ifdef FETCH_HALT_EN
      chk($sformatf("v%0d_halted", i),     64'(halted),         64'(vecs[i].e_halted));
`endif
    end

    // Random-stall run from pc 0, scoreboarded against the bench memory image.
    m_pc = 64'h0;
    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom_range(0, 1));
      if (!rs) begin
        sb.push_back({m_pc, mem[m_pc[9:2]]});
        m_pc = m_pc + 64'd4;
      end
      step(rs, 1'b0, 64'h0, 1'b1);
      chk($sformatf("sb%0d_pc_out", i), pc_out, m_pc);
      if (!rs) begin
        if (sb.size() == 0) begin
          chk($sformatf("sb%0d_queue", i), 64'(sb.size()), 64'd1);
        end else begin
          item = sb.pop_front();
          chk($sformatf("sb%0d_ifid_pc", i),    bus.ifid_pc,         item[95:32]);
          chk($sformatf("sb%0d_ifid_instr", i), 64'(bus.ifid_instr), 64'(item[31:0]));
          chk($sformatf("sb%0d_ifid_valid", i), 64'(bus.ifid_valid), 64'h1);
        end
      end
    end
    chk("sb_drained", 64'(sb.size()), 64'h0);

    // Reset asserted mid-run at pc 0x80 discards in-flight state.
    step(1'b0, 1'b1, 64'h7C, 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    chk("mid_pc_before",   pc_out,              64'h80);
    chk("mid_valid_before", 64'(bus.ifid_valid), 64'h1);
    step(1'b0, 1'b0, 64'h0, 1'b0);
    chk("mid_rst_pc_out",  pc_out,              64'h0);
    chk("mid_rst_valid",   64'(bus.ifid_valid), 64'h0);
    chk("mid_rst_instr",   64'(bus.ifid_instr), 64'(NOP));
    step(1'b0, 1'b0, 64'h0, 1'b1);
    chk("mid_rel_ifid_pc", bus.ifid_pc,         64'h0);
    chk("mid_rel_instr",   64'(bus.ifid_instr), 64'hF800_0001);
    chk("mid_rel_valid",   64'(bus.ifid_valid), 64'h1);
    chk("mid_rel_pc_out",  pc_out,              64'h4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
